neuron_sequencer: RTL and testbench
===================================

Name: neuron_sequencer

Overview:
- Control FSM directly upstream of the neuron datapath. Drives the datapath strobes: clear_acc, x_write, w_write, acc_en, ready, res_write.
- Issues read addresses to the synchronous input (x) and weight memories.
- Steps one neuron evaluation over d input/weight pairs: clear accumulator, d multiply-accumulate steps, activation, result write.
- Handshakes with the layer controller above via start/busy/done.

Parameters:
- N, 16, datapath word width. Passed through for consistency; no arithmetic is done here.
- d, 8, number of input/weight pairs per neuron. Legal range 1 to 2^AW.
- AW, 3, address width of x_addr/w_addr.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  reset; asynchronous, active-low (0 = reset).
- start  in  1  request one neuron evaluation; sampled only in IDLE.
- busy  out  1  high from CLEAR through WRITE inclusive.
- done  out  1  one-cycle pulse in DONE state.
- mem_rd  out  1  read enable to x and weight memories; 1-cycle read latency.
- x_addr  out  AW  input memory address.
- w_addr  out  AW  weight memory address; always equal to x_addr.
- clear_acc  out  1  zero datapath accumulator.
- x_write  out  1  latch memory x data into datapath x register.
- w_write  out  1  latch memory weight data into datapath w register.
- acc_en  out  1  acc <= acc + x*w.
- ready  out  1  activation function input valid.
- res_write  out  1  latch accumulator/activation result into result register.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, element counter=0, x_addr=w_addr=0.
  - All 1-bit outputs = 0.
  - Takes effect immediately, mid-operation included. No partial done or res_write after release.
- Moore FSM. Every strobe is decoded from the registered state only; no output depends combinationally on start.
- Element counter cnt is AW+1 bits, so d=2^AW terminates without wrap.
- States and transitions:
  - IDLE: busy=0. If start=1 at the clock edge -> CLEAR, else stay.
  - CLEAR: clear_acc=1; cnt<=0 -> ADDR.
  - ADDR: mem_rd=1, x_addr=w_addr=cnt[AW-1:0] -> LOAD.
  - LOAD: x_write=w_write=1, capturing memory data valid this cycle -> MAC.
  - MAC: acc_en=1; cnt<=cnt+1. If cnt==d-1 -> ACT, else -> ADDR.
  - ACT: ready=1 -> WRITE.
  - WRITE: ready=1, res_write=1 -> DONE.
  - DONE: done=1, busy=0 -> IDLE.
- Addresses hold their last driven value outside ADDR; they change only in ADDR.
- Strobes are mutually exclusive except ready+res_write in WRITE.
- Latency: with CLEAR as cycle 1 after start is sampled, done is high in cycle 3d+4.
  - Throughput: one neuron per 3d+5 cycles including the IDLE cycle.
- Boundary conditions:
  - start while busy or in DONE: ignored, not queued.
  - start held high continuously: a new evaluation begins on the IDLE cycle after each DONE.
  - d=1: single ADDR/LOAD/MAC pass, done in cycle 7.
  - cnt never exceeds d.
  - x_addr sequence per evaluation is exactly 0..d-1, each presented once.

Test Plan:
- Reset check: hold rst=0 -> all outputs 0, x_addr=0. Release rst, start=0 for 10 cycles -> stays IDLE, busy=0.
- Nominal run, d=8: one-cycle start pulse ->
  - clear_acc in cycle 1.
  - x_addr=0..7 on mem_rd cycles 2,5,...,23.
  - acc_en count=8; ready in cycles 26-27; res_write in cycle 27.
  - done pulse in cycle 28; busy high cycles 1-27.
- Datapath co-sim, N=16, d=4: memory x={1,2,3,4}, w={5,6,7,8} -> result register =70 when done pulses.
- start asserted during MAC and during DONE -> ignored. Exactly one done; next run only after a start sampled in IDLE.
- Async reset (rst=0 mid-cycle) during LOAD of element 3 -> outputs drop to 0 immediately, no res_write or done. A fresh start then restarts from x_addr=0.
- Boundary d=1 and d=8 with AW=3: d=1 gives done in cycle 7; d=8 covers all 8 addresses with no wrap, and cnt reaches 8 only at exit.

Source files
------------

// File: rtl/neuron_sequencer.sv
// rtl/neuron_sequencer.sv - neuron evaluation control FSM
// Sequences clear, d address/load/MAC passes, activation and result write.
module neuron_sequencer #(
  parameter int N  = 16,
  parameter int d  = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          mem_rd,
  output logic [AW-1:0] x_addr,
  output logic [AW-1:0] w_addr,
  output logic          clear_acc,
  output logic          x_write,
  output logic          w_write,
  output logic          acc_en,
  output logic          ready,
  output logic          res_write
);

  if (N < 1 || d < 1 || d > (1 << AW)) begin : g_param_check
    $error("neuron_sequencer: illegal N/d/AW combination");
  end

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CLEAR = 3'd1;
  localparam logic [2:0] ADDR  = 3'd2;
  localparam logic [2:0] LOAD  = 3'd3;
  localparam logic [2:0] MAC   = 3'd4;
  localparam logic [2:0] ACT   = 3'd5;
  localparam logic [2:0] WRITE = 3'd6;
  localparam logic [2:0] DONE  = 3'd7;

  localparam logic [AW:0]   CNT_LAST = (AW+1)'(d - 1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] ADDR_ONE = AW'(1);

  logic [2:0]    state;
  logic [AW:0]   cnt;
  logic [AW-1:0] addr_q;

  // The address register is loaded on the edge entering ADDR, so it is
  // valid during ADDR and holds its value everywhere else.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      addr_q <= '0;
    end else begin
      case (state)
        IDLE:  if (start) state <= CLEAR;
        CLEAR: begin
          cnt    <= '0;
          addr_q <= '0;
          state  <= ADDR;
        end
        ADDR:  state <= LOAD;
        LOAD:  state <= MAC;
        MAC: begin
          cnt <= cnt + CNT_ONE;
          if (cnt == CNT_LAST) begin
            state <= ACT;
          end else begin
            addr_q <= cnt[AW-1:0] + ADDR_ONE;
            state  <= ADDR;
          end
        end
        ACT:   state <= WRITE;
        WRITE: state <= DONE;
        DONE:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    busy      = (state != IDLE) && (state != DONE);
    done      = (state == DONE);
    mem_rd    = (state == ADDR);
    clear_acc = (state == CLEAR);
    x_write   = (state == LOAD);
    w_write   = (state == LOAD);
    acc_en    = (state == MAC);
    ready     = (state == ACT) || (state == WRITE);
    res_write = (state == WRITE);
  end

  assign x_addr = addr_q;
  assign w_addr = addr_q;

endmodule

// File: tb/tb_neuron_sequencer.sv
// tb/tb_neuron_sequencer.sv - directed bench for neuron_sequencer
// Three instances (d=8, d=4 with a datapath model, d=1) checked cycle by cycle.
module tb_neuron_sequencer;

  logic clk;
  logic rst;
  logic start0, start1, start2;

  logic       busy0, done0, rd0, clr0, xw0, ww0, acc0, rdy0, rw0;
  logic       busy1, done1, rd1, clr1, xw1, ww1, acc1, rdy1, rw1;
  logic       busy2, done2, rd2, clr2, xw2, ww2, acc2, rdy2, rw2;
  logic [2:0] xa0, wa0, xa1, wa1, xa2, wa2;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  neuron_sequencer #(.N(16), .d(8), .AW(3)) u0 (
    .clk(clk), .rst(rst), .start(start0), .busy(busy0), .done(done0),
    .mem_rd(rd0), .x_addr(xa0), .w_addr(wa0), .clear_acc(clr0),
    .x_write(xw0), .w_write(ww0), .acc_en(acc0), .ready(rdy0), .res_write(rw0)
  );

  neuron_sequencer #(.N(16), .d(4), .AW(3)) u1 (
    .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
    .mem_rd(rd1), .x_addr(xa1), .w_addr(wa1), .clear_acc(clr1),
    .x_write(xw1), .w_write(ww1), .acc_en(acc1), .ready(rdy1), .res_write(rw1)
  );

  neuron_sequencer #(.N(16), .d(1), .AW(3)) u2 (
    .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2),
    .mem_rd(rd2), .x_addr(xa2), .w_addr(wa2), .clear_acc(clr2),
    .x_write(xw2), .w_write(ww2), .acc_en(acc2), .ready(rdy2), .res_write(rw2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath model for the d=4 instance: synchronous memories plus MAC.
  logic [15:0] xm [8];
  logic [15:0] wm [8];
  logic [15:0] x_rd, w_rd, x_reg, w_reg, acc, res;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_rd <= '0; w_rd <= '0; x_reg <= '0; w_reg <= '0; acc <= '0; res <= '0;
    end else begin
      if (rd1) begin
        x_rd <= xm[xa1];
        w_rd <= wm[wa1];
      end
      if (xw1) x_reg <= x_rd;
      if (ww1) w_reg <= w_rd;
      if (clr1) acc <= '0;
      else if (acc1) acc <= acc + x_reg * w_reg;
      if (rw1) res <= acc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] vec(input int i);
    case (i)
      0: vec = {busy0, done0, rd0, clr0, xw0, ww0, acc0, rdy0, rw0};
      1: vec = {busy1, done1, rd1, clr1, xw1, ww1, acc1, rdy1, rw1};
      default: vec = {busy2, done2, rd2, clr2, xw2, ww2, acc2, rdy2, rw2};
    endcase
  endfunction

  function automatic logic [5:0] addrs(input int i);
    case (i)
      0: addrs = {wa0, xa0};
      1: addrs = {wa1, xa1};
      default: addrs = {wa2, xa2};
    endcase
  endfunction

  task automatic set_start(input int i, input logic v);
    case (i)
      0: start0 = v;
      1: start1 = v;
      default: start2 = v;
    endcase
  endtask

  // Expected strobes for cycle cc of an evaluation (cycle 1 = CLEAR).
  function automatic logic [8:0] ev(input int cc, input int d);
    logic b, dn, rd, cl, xw, ac, ry, rw;
    b  = (cc >= 1) && (cc <= 3*d + 3);
    dn = (cc == 3*d + 4);
    cl = (cc == 1);
    rd = (cc >= 2) && (cc <= 3*d - 1) && ((cc - 2) % 3 == 0);
    xw = (cc >= 3) && (cc <= 3*d) && (cc % 3 == 0);
    ac = (cc >= 4) && (cc <= 3*d + 1) && ((cc - 4) % 3 == 0);
    ry = (cc == 3*d + 2) || (cc == 3*d + 3);
    rw = (cc == 3*d + 3);
    ev = {b, dn, rd, cl, xw, xw, ac, ry, rw};
  endfunction

  // mode 0: start pulse; mode 1: extra start during MAC and DONE;
  // mode 2: start held high across two back-to-back evaluations.
  task automatic run(input int i, input int d, input int prev, input int mode, input int ncyc);
    int p, cc, ea;
    logic [2:0] a3;
    p = 3*d + 5;
    set_start(i, 1'b1);
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      cc = (mode == 2) ? ((c - 1) % p) + 1 : c;
      check($sformatf("strobes i%0d m%0d c%0d", i, mode, c), {23'd0, vec(i)}, {23'd0, ev(cc, d)});
      if (cc == 1) ea = (c == 1) ? prev : d - 1;
      else ea = ((cc - 2) / 3 < d - 1) ? (cc - 2) / 3 : d - 1;
      a3 = ea[2:0];
      check($sformatf("addr i%0d m%0d c%0d", i, mode, c), {26'd0, addrs(i)}, {26'd0, a3, a3});
      if (i == 0 && cc == 3*d + 2) check("cnt_at_exit", {28'd0, u0.cnt}, d);
      if (i == 1 && cc == 3*d + 4) check("dot_result", {16'd0, res}, 32'd70);
      case (mode)
        1: set_start(i, (c == 4) || (c == 3*d + 4));
        2: set_start(i, c < ncyc - 1);
        default: set_start(i, 1'b0);
      endcase
    end
  endtask

  initial begin
    xm[0] = 16'd1; xm[1] = 16'd2; xm[2] = 16'd3; xm[3] = 16'd4;
    wm[0] = 16'd5; wm[1] = 16'd6; wm[2] = 16'd7; wm[3] = 16'd8;
    for (int k = 4; k < 8; k++) begin
      xm[k] = 16'hdead;
      wm[k] = 16'hbeef;
    end
    rst = 1'b0;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;

    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset_strobes i%0d", i), {23'd0, vec(i)}, 32'd0);
      check($sformatf("reset_addr i%0d", i), {26'd0, addrs(i)}, 32'd0);
    end

    rst = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++)
        check($sformatf("idle i%0d c%0d", i, c), {23'd0, vec(i)}, 32'd0);
    end

    run(0, 8, 0, 0, 29);
    run(1, 4, 0, 0, 17);
    run(0, 8, 7, 1, 31);
    run(2, 1, 0, 2, 16);

    // Asynchronous reset in the LOAD cycle of element 3 (cycle 12).
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (11) @(negedge clk);
    check("pre_reset_strobes", {23'd0, vec(0)}, {23'd0, ev(12, 8)});
    check("pre_reset_addr", {26'd0, addrs(0)}, {26'd0, 6'o33});
    #2 rst = 1'b0;
    #1;
    check("async_reset_strobes", {23'd0, vec(0)}, 32'd0);
    check("async_reset_addr", {26'd0, addrs(0)}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      check($sformatf("post_reset_idle c%0d", c), {23'd0, vec(0)}, 32'd0);
    end
    run(0, 8, 0, 0, 29);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
